// File: rtl/bitand20_rr_sched_if.sv
// Request/response bundle for the round-robin AND scheduler.
// master drives operands and resp_ready; slave is the scheduler.
interface bitand20_rr_sched_if #(
    parameter int W    = 20,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic [W-1:0]      resp_data;
    logic [IDW-1:0]    resp_id;
    logic              resp_ready;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/bitand20_rr_sched.sv
// Round-robin scheduler sharing one W-bit AND unit across NREQ requesters.
// Define BITAND20_STAT_EN to add the 16-bit op_count transfer counter.
module bitand20_rr_sched #(
    parameter int W    = 20,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input logic clk,
    input logic rst_n,
    bitand20_rr_sched_if.slave bus
`ifdef BITAND20_STAT_EN
    ,
    output logic [15:0] op_count
`endif
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic            free;
    logic            fire;
    logic [NREQ-1:0] ready;
    logic [W-1:0]    data_q;
    logic [IDW-1:0]  id_q;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr_q + IDW'(k);
            if (!gnt_any && bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign free = (state_q == EMPTY) || bus.resp_ready;
    assign fire = gnt_any && free && rst_n;

    always_comb begin
        ready = '0;
        if (fire) ready[gnt_idx] = 1'b1;
    end

    assign bus.req_ready = ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (fire) state_d = FULL;
            FULL:  if (bus.resp_ready && !fire) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            id_q   <= '0;
            ptr_q  <= '0;
        end else if (fire) begin
            data_q <= bus.req_a[gnt_idx*W +: W] & bus.req_b[gnt_idx*W +: W];
            id_q   <= gnt_idx;
            ptr_q  <= gnt_idx + IDW'(1);
        end
    end

    assign bus.resp_valid = (state_q == FULL);
    assign bus.resp_data  = data_q;
    assign bus.resp_id    = id_q;

`ifdef BITAND20_STAT_EN
    logic [15:0] op_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_cnt <= '0;
        else if (bus.resp_valid && bus.resp_ready)
            op_cnt <= op_cnt + 16'd1;
    end

    assign op_count = op_cnt;
`endif
endmodule
